// File: rtl/rtic_pkg.sv
// Shared constants and word packing for the real-time input capture core.
package rtic_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int unsigned ARM_CYCLES = 3;
    localparam int unsigned TS_W       = 64;
    localparam int unsigned WORD_W     = 128;

    // Build the host word: timestamp in the upper half, zero-extended levels below.
    function automatic logic [WORD_W-1:0] pack_word(input logic [TS_W-1:0] ts,
                                                    input logic [TS_W-1:0] levels);
        return {ts, levels};
    endfunction

endpackage

// File: rtl/rtic_fifo.sv
// First-word-fall-through FIFO on an inferred RAM; head word is 0 while empty.
module rtic_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW      = DEPTH;
    localparam int unsigned CW      = DEPTH + 1;
    localparam int unsigned ENTRIES = 1 << DEPTH;

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count + CW'(wr_en) - CW'(rd_en);
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(ENTRIES));
            empty <= (count_next == '0);
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rtic_core.sv
// Real-time input capture: synchronize TTL lines, timestamp edges, queue for the host.
module rtic_core
    import rtic_pkg::*;
#(
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned DATA_LEN  = 1,
    parameter int unsigned TS_OFFSET = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                auto_start,
    input  logic                flush,
    input  logic [1:0]          edge_mode,
    input  logic [DATA_LEN-1:0] ttl_in,
    input  logic [63:0]         counter,
    input  logic                read,
    output logic [127:0]        rti_out,
    output logic                overflow_error,
    output logic [127:0]        overflow_error_data,
    output logic                underflow_error,
    output logic [DEPTH:0]      count,
    output logic                full,
    output logic                empty
);

    localparam int unsigned ARM_W = $clog2(ARM_CYCLES + 1);

    logic [DATA_LEN-1:0] s1;
    logic [DATA_LEN-1:0] s2;
    logic [DATA_LEN-1:0] prev;
    logic [ARM_W-1:0]    arm_cnt;
    logic                armed;
    logic                rise_any;
    logic                fall_any;
    logic                hit;
    logic                evt;
    logic                wr_en;
    logic                rd_en;
    logic                drop;
    logic [WORD_W-1:0]   evt_word;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= ttl_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Mask detection until the synchronizer chain has primed after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt <= '0;
        end else if (arm_cnt != ARM_W'(ARM_CYCLES)) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    // Edge qualification and FIFO handshake decisions.
    always_comb begin
        rise_any = |(s2 & ~prev);
        fall_any = |(~s2 & prev);
        hit      = 1'b0;
        case (edge_mode)
            EDGE_RISE: hit = rise_any;
            EDGE_FALL: hit = fall_any;
            EDGE_BOTH: hit = rise_any | fall_any;
            EDGE_NONE: hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        evt      = hit & auto_start & armed;
        evt_word = pack_word(counter - TS_W'(TS_OFFSET), TS_W'(s2));
        wr_en    = evt & ~flush & (~full | read);
        rd_en    = read & ~empty & ~flush;
        drop     = evt & ~flush & full & ~read;
    end

    // Overflow/underflow pulses and the captured dropped word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_error      <= 1'b0;
            overflow_error_data <= '0;
            underflow_error     <= 1'b0;
        end else if (flush) begin
            overflow_error      <= 1'b0;
            overflow_error_data <= '0;
            underflow_error     <= 1'b0;
        end else begin
            overflow_error  <= drop;
            underflow_error <= read & empty;
            if (drop) begin
                overflow_error_data <= evt_word;
            end
        end
    end

    rtic_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (evt_word),
        .rd_en   (rd_en),
        .rd_data (rti_out),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_rtic_core.sv
// Directed bench for rtic_core: edges, timestamps, overflow, underflow, flush, wrap.
module tb_rtic_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         auto_start;
    logic         flush;
    logic [1:0]   edge_mode;
    logic [0:0]   ttl;
    logic [63:0]  counter;
    logic         read;
    logic [127:0] rti_out;
    logic         overflow_error;
    logic [127:0] overflow_error_data;
    logic         underflow_error;
    logic [10:0]  count;
    logic         full;
    logic         empty;

    int checks   = 0;
    int failures = 0;

    rtic_core #(.DEPTH(10), .DATA_LEN(1), .TS_OFFSET(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .auto_start          (auto_start),
        .flush               (flush),
        .edge_mode           (edge_mode),
        .ttl_in              (ttl),
        .counter             (counter),
        .read                (read),
        .rti_out             (rti_out),
        .overflow_error      (overflow_error),
        .overflow_error_data (overflow_error_data),
        .underflow_error     (underflow_error),
        .count               (count),
        .full                (full),
        .empty               (empty)
    );

    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        counter = counter + 64'd1;
    endtask

    task automatic pop();
        read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; auto_start = 1'b1; flush = 1'b0; edge_mode = 2'b11;
        ttl = 1'b1; counter = 64'd0; read = 1'b0;
        repeat (3) step();
        checks++;
        if (rti_out !== 128'd0 || overflow_error !== 1'b0 || overflow_error_data !== 128'd0 ||
            underflow_error !== 1'b0 || count !== 11'd0 || full !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: rti=%h ovf=%b ovfd=%h unf=%b count=%0d full=%b empty=%b",
                     rti_out, overflow_error, overflow_error_data, underflow_error, count, full, empty);
        end
        reset = 1'b1;
        repeat (8) step();
        checks++;
        if (count !== 11'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL high_at_release: count=%0d empty=%b exp 0/1", count, empty);
        end
    endtask

    task automatic test_rise();
        edge_mode = 2'b01;
        ttl = 1'b0;
        repeat (4) step();
        checks++;
        if (count !== 11'd0) begin
            failures++;
            $display("FAIL fall_ignored_in_rise_mode: count=%0d exp 0", count);
        end
        counter = 64'd100; ttl = 1'b1;
        step(); step();
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL rise_latency_early: empty=%b exp 1", empty);
        end
        step();
        checks++;
        if (empty !== 1'b0 || count !== 11'd1) begin
            failures++;
            $display("FAIL rise_written: empty=%b count=%0d exp 0/1", empty, count);
        end
        checks++;
        if (rti_out !== {64'd100, 63'd0, 1'b1}) begin
            failures++;
            $display("FAIL rise_word: got %h exp %h", rti_out, {64'd100, 63'd0, 1'b1});
        end
        pop();
        checks++;
        if (empty !== 1'b1 || rti_out !== 128'd0) begin
            failures++;
            $display("FAIL rise_pop: empty=%b rti=%h exp 1/0", empty, rti_out);
        end
        ttl = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_both_edges();
        edge_mode = 2'b11;
        counter = 64'd200; ttl = 1'b1;
        repeat (5) step();
        ttl = 1'b0;
        repeat (4) step();
        checks++;
        if (count !== 11'd2 || rti_out !== {64'd200, 64'd1}) begin
            failures++;
            $display("FAIL both_first: count=%0d rti=%h exp 2 %h", count, rti_out, {64'd200, 64'd1});
        end
        pop();
        checks++;
        if (count !== 11'd1 || rti_out !== {64'd205, 64'd0}) begin
            failures++;
            $display("FAIL both_second: count=%0d rti=%h exp 1 %h", count, rti_out, {64'd205, 64'd0});
        end
        pop();
        edge_mode = 2'b01;
        counter = 64'd300; ttl = 1'b1;
        repeat (5) step();
        ttl = 1'b0;
        repeat (4) step();
        checks++;
        if (count !== 11'd1 || rti_out !== {64'd300, 64'd1}) begin
            failures++;
            $display("FAIL rise_only_pulse: count=%0d rti=%h exp 1 %h", count, rti_out, {64'd300, 64'd1});
        end
        pop();
        edge_mode = 2'b11;
    endtask

    task automatic test_disabled();
        auto_start = 1'b0;
        ttl = 1'b1;
        repeat (4) step();
        ttl = 1'b0;
        repeat (4) step();
        edge_mode = 2'b00;
        ttl = 1'b1;
        auto_start = 1'b1;
        repeat (4) step();
        ttl = 1'b0;
        repeat (4) step();
        checks++;
        if (count !== 11'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL disabled_capture: count=%0d empty=%b exp 0/1", count, empty);
        end
        edge_mode = 2'b11;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 1024; i++) begin
            ttl = ~ttl;
            step();
        end
        repeat (4) step();
        checks++;
        if (count !== 11'd1024 || full !== 1'b1 || overflow_error !== 1'b0) begin
            failures++;
            $display("FAIL fill: count=%0d full=%b ovf=%b exp 1024/1/0", count, full, overflow_error);
        end
        counter = 64'd5000; ttl = ~ttl;
        step(); step(); step();
        checks++;
        if (overflow_error !== 1'b1 || count !== 11'd1024) begin
            failures++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d exp 1/1024", overflow_error, count);
        end
        checks++;
        if (overflow_error_data !== {64'd5000, 64'd1}) begin
            failures++;
            $display("FAIL overflow_data: got %h exp %h", overflow_error_data, {64'd5000, 64'd1});
        end
        step();
        checks++;
        if (overflow_error !== 1'b0) begin
            failures++;
            $display("FAIL overflow_one_cycle: ovf=%b exp 0", overflow_error);
        end
        counter = 64'd6000; ttl = ~ttl;
        step(); step();
        read = 1'b1;
        step();
        read = 1'b0;
        checks++;
        if (overflow_error !== 1'b0 || count !== 11'd1024 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_with_read: ovf=%b count=%0d full=%b exp 0/1024/1",
                     overflow_error, count, full);
        end
        checks++;
        if (overflow_error_data !== {64'd5000, 64'd1}) begin
            failures++;
            $display("FAIL overflow_data_hold: got %h exp %h", overflow_error_data, {64'd5000, 64'd1});
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (count !== 11'd0 || empty !== 1'b1 || full !== 1'b0 || overflow_error_data !== 128'd0) begin
            failures++;
            $display("FAIL flush_full: count=%0d empty=%b full=%b ovfd=%h exp 0/1/0/0",
                     count, empty, full, overflow_error_data);
        end
        for (int i = 0; i < 10; i++) begin
            ttl = ~ttl;
            step();
        end
        repeat (4) step();
        checks++;
        if (count !== 11'd10) begin
            failures++;
            $display("FAIL queue_ten: count=%0d exp 10", count);
        end
        ttl = ~ttl;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (count !== 11'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_ten: count=%0d empty=%b exp 0/1", count, empty);
        end
        step();
        checks++;
        if (count !== 11'd0 || rti_out !== 128'd0) begin
            failures++;
            $display("FAIL flush_discard_event: count=%0d rti=%h exp 0/0", count, rti_out);
        end
    endtask

    task automatic test_underflow();
        pop();
        checks++;
        if (underflow_error !== 1'b1 || count !== 11'd0) begin
            failures++;
            $display("FAIL underflow_pulse: unf=%b count=%0d exp 1/0", underflow_error, count);
        end
        step();
        checks++;
        if (underflow_error !== 1'b0) begin
            failures++;
            $display("FAIL underflow_one_cycle: unf=%b exp 0", underflow_error);
        end
        counter = 64'd700; ttl = ~ttl;
        step(); step();
        read = 1'b1;
        step();
        read = 1'b0;
        checks++;
        if (count !== 11'd1 || underflow_error !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL read_write_empty: count=%0d unf=%b empty=%b exp 1/1/0",
                     count, underflow_error, empty);
        end
        checks++;
        if (rti_out[127:64] !== 64'd700) begin
            failures++;
            $display("FAIL read_write_empty_ts: got %0d exp 700", rti_out[127:64]);
        end
        pop();
    endtask

    task automatic test_wrap();
        counter = 64'hFFFF_FFFF_FFFF_FFFF; ttl = ~ttl;
        step(); step(); step();
        checks++;
        if (count !== 11'd1 || rti_out[127:64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL ts_wrap: count=%0d ts=%h exp 1 ffffffffffffffff", count, rti_out[127:64]);
        end
        pop();
    endtask

    task automatic test_async_reset();
        ttl = ~ttl;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 11'd0 || empty !== 1'b1 || rti_out !== 128'd0) begin
            failures++;
            $display("FAIL async_reset: count=%0d empty=%b rti=%h exp 0/1/0", count, empty, rti_out);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_rise();
        test_both_edges();
        test_disabled();
        test_overflow();
        test_flush();
        test_underflow();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
